// File: rtl/instr_loader_pkg.sv
// Shared CPU package: instruction/address widths and the program-loader state encoding.
// Imported by instr_loader, the CPU core and the instruction memory so all agree on sizes.
package instr_loader_pkg;

  // Instruction word width and instruction-memory address width (256 words).
  localparam int unsigned CPU_INSTR_W = 18;
  localparam int unsigned CPU_ADDR_W  = 8;

  // Program loader states.
  typedef enum logic [3:0] {
    StIdle,
    StCount,
    StB0,
    StB1,
    StB2,
    StWrite,
    StCheck,
    StDone,
    StErr
  } ld_state_e;

endpackage

// File: rtl/instr_loader.sv
// instr_loader: receives a program over a byte stream and writes it into instruction memory
// while holding the CPU in reset.
//
// Stream format: count byte N (1..255), then N words of three bytes each (B0 carries bits
// [17:16] in its low bits, B1 bits [15:8], B2 bits [7:0]), then an XOR checksum of every
// preceding byte of the load (count included, all 8 bits of each byte).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        begin a program load (honoured only in idle/done/error)
//   in_data      program byte
//   in_valid     in_data valid
//   in_ready     loader can accept a byte this cycle
//   im_we        instruction-memory write strobe (one cycle per word)
//   im_addr      instruction-memory write address
//   im_wdata     instruction-memory write data
//   cpu_hold     1 keeps the CPU in reset; released only after a good load
//   done         load finished with a matching checksum
//   error        load failed (zero count or bad checksum)
//   words_loaded words written in the current load
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned INSTR_W = CPU_INSTR_W,
  parameter int unsigned ADDR_W  = CPU_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  words_loaded
);

  ld_state_e          state_q, state_d;
  logic [7:0]         count_q, count_d;
  logic [7:0]         csum_q, csum_d;
  logic [INSTR_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  words_q, words_d;
  logic               accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      csum_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    csum_d   = csum_q;
    word_d   = word_q;
    addr_d   = addr_q;
    words_d  = words_q;
    in_ready = 1'b0;
    im_we    = 1'b0;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StCount;
          csum_d  = 8'h00;
          words_d = '0;
        end
      end
      StCount: begin
        in_ready = 1'b1;
        if (accept) begin
          if (in_data == 8'h00) begin
            state_d = StErr;
          end else begin
            count_d = in_data;
            csum_d  = csum_q ^ in_data;
            addr_d  = '0;
            state_d = StB0;
          end
        end
      end
      StB0: begin
        in_ready = 1'b1;
        if (accept) begin
          // Only the bits above [15:0] come from B0; the rest of the byte is padding.
          word_d[INSTR_W-1:16] = in_data[INSTR_W-17:0];
          csum_d  = csum_q ^ in_data;
          state_d = StB1;
        end
      end
      StB1: begin
        in_ready = 1'b1;
        if (accept) begin
          word_d[15:8] = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = StB2;
        end
      end
      StB2: begin
        in_ready = 1'b1;
        if (accept) begin
          word_d[7:0] = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        im_we   = 1'b1;
        addr_d  = addr_q + ADDR_W'(1);
        words_d = words_q + ADDR_W'(1);
        // N <= 255 so the address never wraps.
        state_d = (words_d == ADDR_W'(count_q)) ? StCheck : StB0;
      end
      StCheck: begin
        in_ready = 1'b1;
        if (accept) begin
          state_d = (in_data == csum_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status is decoded from the state register, so done/error are mutually exclusive and
  // cpu_hold drops on the same edge that enters StDone.
  assign im_addr      = addr_q;
  assign im_wdata     = word_q;
  assign done         = (state_q == StDone);
  assign error        = (state_q == StErr);
  assign cpu_hold     = (state_q != StDone);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: table of loads plus hand-written reset/start sequences.
// Expected memory writes go into a queue as words are sent and are popped by a monitor
// whenever im_we is seen.
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int unsigned IW = CPU_INSTR_W;
  localparam int unsigned AW = CPU_ADDR_W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [IW-1:0] im_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW-1:0] words_loaded;

  instr_loader #(.INSTR_W(IW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wr_t;

  typedef struct {
    int         n;         // word count byte
    int         src;       // 0: one-word program, 1: seven-word program, 2: random words
    logic [7:0] bad;       // XORed into the checksum byte sent
    int         gap;       // idle cycles before each byte
    bit         exp_done;  // 1: expect done, 0: expect error
    int         exp_words; // expected words_loaded and write count
  } vec_t;

  wr_t           exp_q[$];
  logic [IW-1:0] wbuf[256];
  vec_t          vecs[7];
  int            compared = 0;
  int            mismatched = 0;
  int            writes_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor / scoreboard.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (reset) begin
      check("done_error_exclusive", 32'(done & error), 32'd0);
      if (im_we) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: addr %0h data %0h, none pending", im_addr, im_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(im_addr), 32'(e.addr));
          check("write_data", 32'(im_wdata), 32'(e.data));
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive one byte and wait (bounded) for it to be accepted; returns 1 time unit after the
  // accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL byte_accept_timeout: in_ready %0b, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Send word i of wbuf and push its expected write.
  task automatic send_word(input int i, input int gap, input bit junk, inout logic [7:0] cs);
    logic [7:0] b0, b1, b2;
    wr_t w;
    b0 = {junk ? 6'($urandom) : 6'b0, wbuf[i][17:16]};
    b1 = wbuf[i][15:8];
    b2 = wbuf[i][7:0];
    cs = cs ^ b0 ^ b1 ^ b2;
    send_byte(b0, gap);
    send_byte(b1, gap);
    w.addr = AW'(i);
    w.data = wbuf[i];
    exp_q.push_back(w);
    send_byte(b2, gap);
    // Write strobe must be up in the cycle right after the B2 acceptance edge.
    check("write_latency", 32'(im_we), 32'd1);
  endtask

  task automatic run_load(input int n, input logic [7:0] bad, input int gap, input bit junk);
    logic [7:0] cs;
    pulse_start();
    check("start_ready", 32'(in_ready), 32'd1);
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_clear", {29'd0, done, error, |words_loaded}, 32'd0);
    cs = 8'(n);
    send_byte(8'(n), gap);
    if (n != 0) begin
      for (int i = 0; i < n; i++) send_word(i, gap, junk, cs);
      send_byte(cs ^ bad, gap);
    end
  endtask

  task automatic fill_seven();
    wbuf[0] = 18'h08004; wbuf[1] = 18'h24000; wbuf[2] = 18'h20400; wbuf[3] = 18'h04840;
    wbuf[4] = 18'h24801; wbuf[5] = 18'h0CC81; wbuf[6] = 18'h24C00;
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   ws;
    logic [7:0] cs;

    vecs[0] = '{n: 1,   src: 0, bad: 8'h00, gap: 0, exp_done: 1'b1, exp_words: 1};
    vecs[1] = '{n: 7,   src: 1, bad: 8'h00, gap: 0, exp_done: 1'b1, exp_words: 7};
    vecs[2] = '{n: 0,   src: 0, bad: 8'h00, gap: 0, exp_done: 1'b0, exp_words: 0};
    vecs[3] = '{n: 1,   src: 0, bad: 8'h01, gap: 0, exp_done: 1'b0, exp_words: 1};
    vecs[4] = '{n: 1,   src: 0, bad: 8'h00, gap: 1, exp_done: 1'b1, exp_words: 1};
    vecs[5] = '{n: 20,  src: 2, bad: 8'h00, gap: 2, exp_done: 1'b1, exp_words: 20};
    vecs[6] = '{n: 255, src: 2, bad: 8'h00, gap: 0, exp_done: 1'b1, exp_words: 255};

    // Reset state, observed while reset is held.
    #12;
    check("reset_hold", 32'(cpu_hold), 32'd1);
    check("reset_ready", 32'(in_ready), 32'd0);
    check("reset_we", 32'(im_we), 32'd0);
    check("reset_flags", {30'd0, done, error}, 32'd0);
    check("reset_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start_hold", 32'(cpu_hold), 32'd1);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].src == 0) wbuf[0] = 18'h24800;
      else if (vecs[v].src == 1) fill_seven();
      else for (int i = 0; i < 256; i++) wbuf[i] = IW'($urandom);
      ws = writes_seen;
      run_load(vecs[v].n, vecs[v].bad, vecs[v].gap, vecs[v].src == 2);
      check("result_done", 32'(done), 32'(vecs[v].exp_done));
      check("result_error", 32'(error), 32'(!vecs[v].exp_done));
      check("result_hold", 32'(cpu_hold), 32'(!vecs[v].exp_done));
      check("result_words", 32'(words_loaded), 32'(vecs[v].exp_words));
      repeat (3) @(negedge clk);
      check("result_writes", 32'(writes_seen - ws), 32'(vecs[v].exp_words));
      check("result_stable", {30'd0, done, cpu_hold}, {30'd0, vecs[v].exp_done, !vecs[v].exp_done});
      check("pending_writes", 32'(exp_q.size()), 32'd0);
    end

    // Mid-load reset, with a start pulse during the load that must be ignored.
    fill_seven();
    pulse_start();
    cs = 8'd3;
    send_byte(8'd3, 0);
    send_word(0, 0, 1'b0, cs);
    send_byte({6'b0, wbuf[1][17:16]}, 0);
    pulse_start();
    send_byte(wbuf[1][15:8], 0);
    check("start_ignored_words", 32'(words_loaded), 32'd1);
    check("start_ignored_hold", 32'(cpu_hold), 32'd1);
    ws = writes_seen;
    #2 reset = 1'b0;
    #1;
    check("midreset_hold", 32'(cpu_hold), 32'd1);
    check("midreset_ready", 32'(in_ready), 32'd0);
    check("midreset_we", 32'(im_we), 32'd0);
    check("midreset_flags", {30'd0, done, error}, 32'd0);
    check("midreset_words", 32'(words_loaded), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_no_write", 32'(writes_seen - ws), 32'd0);
    check("midreset_idle_ready", 32'(in_ready), 32'd0);
    check("pending_after_reset", 32'(exp_q.size()), 32'd0);

    run_load(7, 8'h00, 0, 1'b0);
    check("reload_done", 32'(done), 32'd1);
    check("reload_hold", 32'(cpu_hold), 32'd0);
    check("reload_words", 32'(words_loaded), 32'd7);
    repeat (2) @(negedge clk);
    check("pending_final", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
